// File: rtl/gen_fifo_rd_rqstr_pkg.sv
// Shared width helpers for the multi-channel read requester.
// Count widths are sized to hold the full range 0..N inclusive.
package gen_fifo_rd_rqstr_pkg;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ch_w(input int ch_n);
        return (ch_n > 1) ? $clog2(ch_n) : 1;
    endfunction

    function automatic int pnd_w(input int pnd_n);
        return cnt_w(pnd_n);
    endfunction

    function automatic int outs_w(input int outs_n);
        return cnt_w(outs_n);
    endfunction

    function automatic int rsp_w(input int rsp_depth);
        return cnt_w(rsp_depth);
    endfunction

endpackage

// File: rtl/gen_fifo_rd_rqstr_rsp_buf.sv
// Show-ahead single-clock response FIFO with occupancy count.
// The caller qualifies push; pop on an empty buffer is ignored.
module gen_fifo_rd_rqstr_rsp_buf
    import gen_fifo_rd_rqstr_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             vld,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign vld      = count != '0;
    assign do_pop   = pop && vld;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/gen_fifo_rd_rqstr.sv
// Multi-channel read requester: round-robin request issue with
// buffer-space reservation and a shared response buffer.
module gen_fifo_rd_rqstr
    import gen_fifo_rd_rqstr_pkg::*;
#(
    parameter int CH_N      = 4,
    parameter int DAT_W     = 4,
    parameter int PND_N     = 8,
    parameter int OUTS_N    = 4,
    parameter int RSP_DEPTH = 8,
    localparam int CH_W   = ch_w(CH_N),
    localparam int PND_W  = pnd_w(PND_N),
    localparam int OUTS_W = outs_w(OUTS_N),
    localparam int RSP_W  = rsp_w(RSP_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CH_N-1:0]        usr_dmd_vec,
    input  logic [CH_N-1:0]        usr_clr_vec,
    input  logic [CH_N-1:0]        fc_vec_rqst_rdy_n,
    output logic                   rd_rqst,
    output logic [CH_W-1:0]        rd_ch_num,
    input  logic                   rsp_vld,
    input  logic [CH_W-1:0]        rsp_ch_num,
    input  logic [DAT_W-1:0]       rsp_dat,
    output logic                   out_vld,
    output logic [CH_W-1:0]        out_ch_num,
    output logic [DAT_W-1:0]       out_dat,
    input  logic                   out_rdy,
    output logic [CH_N*PND_W-1:0]  sts_vec_pnd_count,
    output logic [CH_N*OUTS_W-1:0] sts_vec_outs_count,
    output logic [RSP_W-1:0]       sts_rsp_count,
    output logic [CH_N-1:0]        err_vec_dmd_ovfl,
    output logic [CH_N-1:0]        err_vec_rsp_unxp,
    output logic                   err_rsp_ovfl
);

    typedef struct packed {
        logic [CH_W-1:0]  ch_num;
        logic [DAT_W-1:0] dat;
    } rsp_ent_t;

    logic [PND_W-1:0]  pnd  [CH_N];
    logic [OUTS_W-1:0] outs [CH_N];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_N-1:0]   elig;
    logic [CH_N-1:0]   gnt_vec;
    logic [CH_N-1:0]   rsp_hit;
    logic [CH_N-1:0]   rsp_dec;
    logic [CH_W:0]     pick;
    logic              space_ok;
    logic              gnt_vld;
    logic              buf_full;
    logic              pop;
    logic              push;
    int                outs_total;
    rsp_ent_t          push_ent;
    rsp_ent_t          head_ent;

    // Nearest requester after ptr, wrapping; MSB flags a hit.
    function automatic logic [CH_W:0] rr_pick(
        input logic [CH_N-1:0] req,
        input logic [CH_W-1:0] ptr
    );
        logic [CH_W:0] res;
        int best;
        int d;
        res  = '0;
        best = CH_N;
        for (int c = 0; c < CH_N; c++) begin
            d = (c + 2 * CH_N - int'(ptr) - 1) % CH_N;
            if (req[c] && d < best) begin
                best = d;
                res  = {1'b1, CH_W'(c)};
            end
        end
        return res;
    endfunction

    always_comb begin
        outs_total = 0;
        elig       = '0;
        rsp_hit    = '0;
        rsp_dec    = '0;
        gnt_vec    = '0;
        for (int c = 0; c < CH_N; c++) begin
            outs_total += int'(outs[c]);
            elig[c] = (pnd[c] != '0) && !fc_vec_rqst_rdy_n[c] &&
                      (outs[c] < OUTS_W'(OUTS_N)) && !usr_clr_vec[c];
            rsp_hit[c] = rsp_vld && (rsp_ch_num == CH_W'(c));
            rsp_dec[c] = rsp_hit[c] && (outs[c] != '0);
        end
        space_ok = (outs_total + int'(sts_rsp_count)) < RSP_DEPTH;
        pick     = rr_pick(elig, rr_ptr);
        gnt_vld  = pick[CH_W] && space_ok;
        for (int c = 0; c < CH_N; c++)
            gnt_vec[c] = gnt_vld && (pick[CH_W-1:0] == CH_W'(c));
    end

    assign pop      = out_vld && out_rdy;
    assign buf_full = sts_rsp_count == RSP_W'(RSP_DEPTH);
    assign push     = rsp_vld && (!buf_full || pop);
    assign push_ent = '{ch_num: rsp_ch_num, dat: rsp_dat};

    gen_fifo_rd_rqstr_rsp_buf #(
        .DEPTH (RSP_DEPTH),
        .WIDTH ($bits(rsp_ent_t))
    ) u_rsp_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_ent),
        .pop      (pop),
        .vld      (out_vld),
        .head_dat (head_ent),
        .count    (sts_rsp_count)
    );

    assign out_ch_num = head_ent.ch_num;
    assign out_dat    = head_ent.dat;

    always_comb begin
        sts_vec_pnd_count  = '0;
        sts_vec_outs_count = '0;
        for (int c = 0; c < CH_N; c++) begin
            sts_vec_pnd_count[c*PND_W +: PND_W]    = pnd[c];
            sts_vec_outs_count[c*OUTS_W +: OUTS_W] = outs[c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_N; c++) begin
                pnd[c]  <= '0;
                outs[c] <= '0;
            end
            rr_ptr           <= CH_W'(CH_N - 1);
            rd_rqst          <= 1'b0;
            rd_ch_num        <= '0;
            err_vec_dmd_ovfl <= '0;
            err_vec_rsp_unxp <= '0;
            err_rsp_ovfl     <= 1'b0;
        end else begin
            rd_rqst      <= gnt_vld;
            err_rsp_ovfl <= rsp_vld && !push;
            if (gnt_vld) begin
                rd_ch_num <= pick[CH_W-1:0];
                rr_ptr    <= pick[CH_W-1:0];
            end
            for (int c = 0; c < CH_N; c++) begin
                err_vec_dmd_ovfl[c] <= usr_dmd_vec[c] && !usr_clr_vec[c] &&
                                       !gnt_vec[c] && (pnd[c] == PND_W'(PND_N));
                err_vec_rsp_unxp[c] <= rsp_hit[c] && (outs[c] == '0);
                if (usr_clr_vec[c]) begin
                    pnd[c] <= '0;
                end else begin
                    unique case ({usr_dmd_vec[c], gnt_vec[c]})
                        2'b10: if (pnd[c] != PND_W'(PND_N))
                                   pnd[c] <= pnd[c] + PND_W'(1);
                        2'b01: pnd[c] <= pnd[c] - PND_W'(1);
                        default: ;
                    endcase
                end
                unique case ({gnt_vec[c], rsp_dec[c]})
                    2'b10:   outs[c] <= outs[c] + OUTS_W'(1);
                    2'b01:   outs[c] <= outs[c] - OUTS_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gen_fifo_rd_rqstr.sv
// Directed self-checking bench for gen_fifo_rd_rqstr.
// Default parameters: CH_N=4 DAT_W=4 PND_N=8 OUTS_N=4 RSP_DEPTH=8.
module tb_gen_fifo_rd_rqstr;

    localparam int CH_N = 4;
    localparam int CH_W = 2;
    localparam int DAT_W = 4;
    localparam int PND_W = 4;
    localparam int OUTS_W = 3;
    localparam int RSP_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic [CH_N-1:0]        usr_dmd_vec;
    logic [CH_N-1:0]        usr_clr_vec;
    logic [CH_N-1:0]        fc_vec_rqst_rdy_n;
    logic                   rd_rqst;
    logic [CH_W-1:0]        rd_ch_num;
    logic                   rsp_vld;
    logic [CH_W-1:0]        rsp_ch_num;
    logic [DAT_W-1:0]       rsp_dat;
    logic                   out_vld;
    logic [CH_W-1:0]        out_ch_num;
    logic [DAT_W-1:0]       out_dat;
    logic                   out_rdy;
    logic [CH_N*PND_W-1:0]  sts_vec_pnd_count;
    logic [CH_N*OUTS_W-1:0] sts_vec_outs_count;
    logic [RSP_W-1:0]       sts_rsp_count;
    logic [CH_N-1:0]        err_vec_dmd_ovfl;
    logic [CH_N-1:0]        err_vec_rsp_unxp;
    logic                   err_rsp_ovfl;

    int n_chk;
    int n_fail;
    int cyc;
    int ovfl_cnt;
    logic [CH_W-1:0] rq_q[$];
    int rq_cyc[$];
    int exp_fair[8] = '{3, 0, 1, 2, 3, 0, 1, 2};

    gen_fifo_rd_rqstr u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .usr_dmd_vec        (usr_dmd_vec),
        .usr_clr_vec        (usr_clr_vec),
        .fc_vec_rqst_rdy_n  (fc_vec_rqst_rdy_n),
        .rd_rqst            (rd_rqst),
        .rd_ch_num          (rd_ch_num),
        .rsp_vld            (rsp_vld),
        .rsp_ch_num         (rsp_ch_num),
        .rsp_dat            (rsp_dat),
        .out_vld            (out_vld),
        .out_ch_num         (out_ch_num),
        .out_dat            (out_dat),
        .out_rdy            (out_rdy),
        .sts_vec_pnd_count  (sts_vec_pnd_count),
        .sts_vec_outs_count (sts_vec_outs_count),
        .sts_rsp_count      (sts_rsp_count),
        .err_vec_dmd_ovfl   (err_vec_dmd_ovfl),
        .err_vec_rsp_unxp   (err_vec_rsp_unxp),
        .err_rsp_ovfl       (err_rsp_ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && rd_rqst) begin
            rq_q.push_back(rd_ch_num);
            rq_cyc.push_back(cyc);
        end
        if (rst_n && err_vec_dmd_ovfl[0]) ovfl_cnt <= ovfl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [PND_W-1:0] pnd_of(input int c);
        return PND_W'(sts_vec_pnd_count >> (c * PND_W));
    endfunction

    function automatic logic [OUTS_W-1:0] outs_of(input int c);
        return OUTS_W'(sts_vec_outs_count >> (c * OUTS_W));
    endfunction

    task automatic send_rsp(input int ch, input int dat);
        rsp_vld    = 1'b1;
        rsp_ch_num = CH_W'(ch);
        rsp_dat    = DAT_W'(dat);
        tick();
        rsp_vld = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input int ch, input int dat);
        chk({tag, "_vld"}, out_vld, 1);
        chk({tag, "_ch"}, out_ch_num, ch);
        chk({tag, "_dat"}, out_dat, dat);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        ovfl_cnt = 0;
        rst_n = 1'b0;
        usr_dmd_vec = '0;
        usr_clr_vec = '0;
        fc_vec_rqst_rdy_n = '0;
        rsp_vld = 1'b0;
        rsp_ch_num = '0;
        rsp_dat = '0;
        out_rdy = 1'b0;
        ticks(2);
        rst_n = 1'b1;

        chk("rst_rqst", rd_rqst, 0);
        chk("rst_vld", out_vld, 0);
        chk("rst_pnd", sts_vec_pnd_count, 0);
        chk("rst_outs", sts_vec_outs_count, 0);
        chk("rst_cnt", sts_rsp_count, 0);
        chk("rst_err", {err_vec_dmd_ovfl, err_vec_rsp_unxp, err_rsp_ovfl}, 0);

        // single request on ch2
        usr_dmd_vec = 4'b0100;
        tick();
        usr_dmd_vec = '0;
        chk("one_rq_c1", rd_rqst, 0);
        chk("one_pnd", pnd_of(2), 1);
        tick();
        chk("one_rq_c2", rd_rqst, 1);
        chk("one_ch", rd_ch_num, 2);
        chk("one_outs", outs_of(2), 1);
        tick();
        chk("one_rq_c3", rd_rqst, 0);
        tick();
        send_rsp(2, 10);
        chk("one_ovld", out_vld, 1);
        chk("one_och", out_ch_num, 2);
        chk("one_odat", out_dat, 10);
        chk("one_outs0", outs_of(2), 0);
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        chk("one_empty", out_vld, 0);

        // fairness: 2 demands per channel, rr_ptr sits at 2
        rq_q.delete();
        rq_cyc.delete();
        usr_dmd_vec = 4'b1111;
        ticks(2);
        usr_dmd_vec = '0;
        ticks(8);
        chk("fair_n", rq_q.size(), 8);
        if (rq_q.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("fair_ord", rq_q[i], exp_fair[i]);
            chk("fair_b2b", rq_cyc[7] - rq_cyc[0], 7);
        end
        chk("fair_outs", sts_vec_outs_count, {3'd2, 3'd2, 3'd2, 3'd2});

        // reservation: 8 outstanding fills the buffer budget
        usr_dmd_vec = 4'b0001;
        tick();
        usr_dmd_vec = '0;
        ticks(3);
        chk("rsv_block", rq_q.size(), 8);
        for (int i = 0; i < 8; i++) send_rsp(exp_fair[i], i);
        chk("rsv_cnt", sts_rsp_count, 8);
        chk("rsv_outs", sts_vec_outs_count, 0);
        chk("rsv_still", rq_q.size(), 8);
        pop_chk("rsv_p0", 3, 0);
        tick();
        chk("rsv_rq", rd_rqst, 1);
        chk("rsv_ch", rd_ch_num, 0);
        send_rsp(0, 8);
        for (int i = 1; i < 8; i++) pop_chk("rsv_pop", exp_fair[i], i);
        pop_chk("rsv_last", 0, 8);
        chk("rsv_empty", sts_rsp_count, 0);

        // flow control holds ch1 back
        rq_q.delete();
        fc_vec_rqst_rdy_n = 4'b0010;
        usr_dmd_vec = 4'b1010;
        tick();
        usr_dmd_vec = '0;
        ticks(3);
        chk("fc_n", rq_q.size(), 1);
        if (rq_q.size() >= 1) chk("fc_ch3", rq_q[0], 3);
        fc_vec_rqst_rdy_n = '0;
        tick();
        chk("fc_rq1", rd_rqst, 1);
        chk("fc_ch1", rd_ch_num, 1);
        send_rsp(3, 1);
        send_rsp(1, 2);
        pop_chk("fc_p3", 3, 1);
        pop_chk("fc_p1", 1, 2);

        // clear flushes pending but keeps outstanding
        rq_q.delete();
        usr_dmd_vec = 4'b0010;
        ticks(2);
        usr_dmd_vec = '0;
        ticks(3);
        chk("clr_outs2", outs_of(1), 2);
        chk("clr_rq2", rq_q.size(), 2);
        fc_vec_rqst_rdy_n = 4'b0010;
        usr_dmd_vec = 4'b0010;
        ticks(5);
        usr_dmd_vec = '0;
        chk("clr_pnd5", pnd_of(1), 5);
        usr_clr_vec = 4'b0010;
        tick();
        usr_clr_vec = '0;
        chk("clr_pnd0", pnd_of(1), 0);
        fc_vec_rqst_rdy_n = '0;
        rq_q.delete();
        ticks(4);
        chk("clr_norq", rq_q.size(), 0);
        send_rsp(1, 3);
        send_rsp(1, 4);
        chk("clr_outs0", outs_of(1), 0);
        chk("clr_nounxp", err_vec_rsp_unxp, 0);
        pop_chk("clr_p0", 1, 3);
        pop_chk("clr_p1", 1, 4);

        // unexpected response
        send_rsp(3, 5);
        chk("unxp_on", err_vec_rsp_unxp, 4'b1000);
        tick();
        chk("unxp_off", err_vec_rsp_unxp, 0);
        pop_chk("unxp_buf", 3, 5);

        // demand overflow at PND_N
        fc_vec_rqst_rdy_n = 4'b0001;
        ovfl_cnt = 0;
        usr_dmd_vec = 4'b0001;
        ticks(9);
        usr_dmd_vec = '0;
        ticks(2);
        chk("dovf_cnt", ovfl_cnt, 1);
        chk("dovf_pnd", pnd_of(0), 8);
        usr_clr_vec = 4'b0001;
        tick();
        usr_clr_vec = '0;
        fc_vec_rqst_rdy_n = '0;
        chk("dovf_clr", pnd_of(0), 0);

        // response buffer overflow, then push+pop at full
        for (int i = 0; i < 8; i++) send_rsp(2, i);
        chk("bovf_full", sts_rsp_count, 8);
        send_rsp(2, 15);
        chk("bovf_err", err_rsp_ovfl, 1);
        chk("bovf_cnt", sts_rsp_count, 8);
        out_rdy = 1'b1;
        send_rsp(1, 9);
        out_rdy = 1'b0;
        chk("bovf_pp_cnt", sts_rsp_count, 8);
        chk("bovf_pp_err", err_rsp_ovfl, 0);
        for (int i = 1; i < 8; i++) pop_chk("bovf_pop", 2, i);
        pop_chk("bovf_last", 1, 9);
        chk("bovf_empty", sts_rsp_count, 0);

        // reset mid-operation
        usr_dmd_vec = 4'b0101;
        tick();
        usr_dmd_vec = '0;
        tick();
        chk("mrst_rq", rd_rqst, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_rq0", rd_rqst, 0);
        chk("mrst_pnd", sts_vec_pnd_count, 0);
        chk("mrst_outs", sts_vec_outs_count, 0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
